// File: rtl/video_pkg.sv
// Shared video constants, sync bundle and luma helper for the binary front end
// and the downstream bounding-box stage.
package video_pkg;

    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;

    localparam int LUMA_R_DEF = 77;
    localparam int LUMA_G_DEF = 150;
    localparam int LUMA_B_DEF = 29;

    // Input-to-output latency of binary_erode3x3; overlays downstream align to it.
    localparam int BIN_LAT = 4;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Q0.8 weighted sum; coefficients summing to 256 cannot overflow 16 bits.
    function automatic logic [7:0] rgb_to_luma(input logic [23:0] rgb,
                                               input logic [7:0]  kr,
                                               input logic [7:0]  kg,
                                               input logic [7:0]  kb);
        logic [15:0] sum;
        sum = 16'(kr) * 16'(rgb[23:16]) + 16'(kg) * 16'(rgb[15:8]) + 16'(kb) * 16'(rgb[7:0]);
        return sum[15:8];
    endfunction

endpackage

// File: rtl/line_buffer_1b.sv
// 1-bit simple dual-port line memory with registered, read-before-write output.
module line_buffer_1b #(
    parameter  int DEPTH = 200,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic mem_q [DEPTH];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/binary_erode3x3.sv
// RGB -> luma threshold -> 3x3 binary erosion, with syncs delayed to match.
// Output (x,y) carries the erosion centred on input (x-1,y-1).
module binary_erode3x3
    import video_pkg::*;
#(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 164,
    parameter int LUMA_R = LUMA_R_DEF,
    parameter int LUMA_G = LUMA_G_DEF,
    parameter int LUMA_B = LUMA_B_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_rgb,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [7:0]  i_thresh,
    input  logic        i_erode_en,
    output logic [23:0] o_binary,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    sync_t               sync_in;
    sync_t [BIN_LAT-1:0] sync_q;   // [0] = S1 ... [BIN_LAT-1] = output

    logic [7:0]    luma1_q, thr1_q;
    logic          en1_q;
    logic          b2_q, en2_q, full2_q;
    logic [XW-1:0] xpos2_q;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic          lb0_rd, lb1_rd;
    logic [2:0]    win_top_q, win_mid_q, win_bot_q;
    logic          en3_q, full3_q;
    logic          obj3;
    logic [23:0]   bin_q, bin_d;

    assign sync_in = '{hs: i_hsync, vs: i_vsync, de: i_de};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[BIN_LAT-2:0], sync_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            luma1_q <= '0;
            thr1_q  <= '0;
            en1_q   <= 1'b0;
        end else begin
            luma1_q <= rgb_to_luma(i_rgb, 8'(LUMA_R), 8'(LUMA_G), 8'(LUMA_B));
            thr1_q  <= i_thresh;
            en1_q   <= i_erode_en;
        end
    end

    // col_q/row_q are the coordinates of the pixel currently sitting in S1.
    always_comb begin
        col_d = '0;
        if (sync_q[0].de) col_d = (col_q == X_LAST) ? col_q : col_q + XW'(1);
        row_d = row_q;
        if (sync_q[0].vs)
            row_d = '0;
        else if (sync_q[1].de && !sync_q[0].de)
            row_d = (row_q == Y_LAST) ? '0 : row_q + YW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            b2_q    <= 1'b0;
            en2_q   <= 1'b0;
            xpos2_q <= '0;
            full2_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            b2_q    <= (luma1_q < thr1_q);
            en2_q   <= en1_q;
            xpos2_q <= col_q;
            full2_q <= (col_q >= XW'(2)) && (row_q >= YW'(2));
        end
    end

    // Reads are issued from S1 so the previous rows line up with b2_q in S2;
    // LB1 is fed from LB0's read port, making it the row before LB0.
    line_buffer_1b #(.DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .i_we    (sync_q[1].de),
        .i_waddr (xpos2_q),
        .i_wdata (b2_q),
        .i_raddr (col_q),
        .o_rdata (lb0_rd)
    );

    line_buffer_1b #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .i_we    (sync_q[1].de),
        .i_waddr (xpos2_q),
        .i_wdata (lb0_rd),
        .i_raddr (col_q),
        .o_rdata (lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_top_q <= '0;
            win_mid_q <= '0;
            win_bot_q <= '0;
            en3_q     <= 1'b0;
            full3_q   <= 1'b0;
        end else begin
            if (sync_q[1].de) begin
                win_top_q <= {win_top_q[1:0], lb1_rd};
                win_mid_q <= {win_mid_q[1:0], lb0_rd};
                win_bot_q <= {win_bot_q[1:0], b2_q};
            end
            en3_q   <= en2_q;
            full3_q <= full2_q;
        end
    end

    // Cells left of column 0 or above row 0 count as background via full3_q.
    always_comb begin
        obj3  = en3_q ? (full3_q && (&{win_top_q, win_mid_q, win_bot_q})) : win_bot_q[0];
        bin_d = (sync_q[2].de && obj3) ? COLOR_BLACK : COLOR_WHITE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bin_q <= COLOR_WHITE;
        else     bin_q <= bin_d;
    end

    assign o_binary = bin_q;
    assign o_hsync  = sync_q[BIN_LAT-1].hs;
    assign o_vsync  = sync_q[BIN_LAT-1].vs;
    assign o_de     = sync_q[BIN_LAT-1].de;

endmodule

// File: tb/tb_binary_erode3x3.sv
// Frame-level bench: drives whole frames and compares each output line against
// an image-level threshold + 3x3 erosion model, plus sync delay history.
module tb_binary_erode3x3;
    import video_pkg::*;

    localparam int W   = 72;
    localparam int H   = 44;
    localparam int HBL = 8;
    localparam int LW  = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] rgb = '0;
    logic        hs = 1'b0, vs = 1'b0, de = 1'b0, en = 1'b0;
    logic [7:0]  thr = '0;
    logic [23:0] o_binary;
    logic        o_hsync, o_vsync, o_de;

    binary_erode3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rgb      (rgb),
        .i_hsync    (hs),
        .i_vsync    (vs),
        .i_de       (de),
        .i_thresh   (thr),
        .i_erode_en (en),
        .o_binary   (o_binary),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_de       (o_de)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [23:0] img     [H][W];
    logic [7:0]  thr_a   [H][W];
    bit          en_a    [H][W];
    bit          exp_img [H][W];
    int          exp_blk;

    function automatic int luma_of(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    // Output (x,y) with erosion = all nine pixels of rows y-2..y, cols x-2..x are objects.
    task automatic build_expect();
        bit bw [H][W];
        bit e;
        exp_blk = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                bw[y][x] = luma_of(img[y][x]) < int'(thr_a[y][x]);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (en_a[y][x]) begin
                    e = (x >= 2 && y >= 2);
                    if (e)
                        for (int dy = -2; dy <= 0; dy++)
                            for (int dx = -2; dx <= 0; dx++)
                                e = e & bw[y+dy][x+dx];
                end else begin
                    e = bw[y][x];
                end
                exp_img[y][x] = e;
                if (e) exp_blk++;
            end
    endtask

    function automatic logic [LW-1:0] exp_row(input int y);
        logic [LW-1:0] r;
        r = '0;
        for (int x = 0; x < W; x++) r[x] = exp_img[y][x];
        return r;
    endfunction

    // Input history as sampled by the DUT; hist[3] is what the outputs must show now.
    logic [3:0][2:0] hist = '0;
    initial forever begin
        @(posedge clk);
        if (rst) hist = '0;
        else     hist = {hist[2:0], {hs, vs, de}};
    end

    bit chk_en;
    int sync_err, bad, rows_seen, blk_cnt;
    int last_x, last_y, bx0, bx1, by0, by1;

    initial begin
        int ox, oy;
        logic [LW-1:0] row_obs;
        bit prev_de;
        ox = 0; oy = 0; row_obs = '0; prev_de = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ox = 0; oy = 0; row_obs = '0; prev_de = 0;
            end else begin
                if ({o_hsync, o_vsync, o_de} !== hist[3]) sync_err++;
                if (o_vsync) oy = 0;
                if (o_de) begin
                    if (o_binary !== COLOR_BLACK && o_binary !== COLOR_WHITE) bad++;
                    if (o_binary === COLOR_BLACK) begin
                        blk_cnt++;
                        last_x = ox; last_y = oy;
                        if (ox < bx0) bx0 = ox;
                        if (ox > bx1) bx1 = ox;
                        if (oy < by0) by0 = oy;
                        if (oy > by1) by1 = oy;
                    end
                    if (ox < W) row_obs[ox] = (o_binary === COLOR_BLACK);
                    ox++;
                end else begin
                    if (o_binary !== COLOR_WHITE) bad++;
                    if (prev_de) begin
                        if (chk_en && oy < H) begin
                            check($sformatf("row%0d", oy), row_obs, exp_row(oy));
                            rows_seen++;
                        end
                        oy++; ox = 0; row_obs = '0;
                    end
                end
                prev_de = o_de;
            end
        end
    end

    task automatic cyc(input logic [23:0] p, input logic h, input logic v, input logic d,
                       input logic [7:0] t, input logic e);
        @(posedge clk); #1;
        rgb = p; hs = h; vs = v; de = d; thr = t; en = e;
    endtask

    task automatic blank_line(input bit v);
        for (int c = 0; c < W + HBL; c++)
            cyc(24'($urandom), c < 4, v, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic run_frame(input string name, input int rst_line);
        build_expect();
        sync_err = 0; bad = 0; rows_seen = 0; blk_cnt = 0;
        last_x = -1; last_y = -1; bx0 = 1000; bx1 = -1; by0 = 1000; by1 = -1;
        chk_en = (rst_line < 0);
        blank_line(1);
        blank_line(0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == rst_line && x == W / 2) begin
                    @(posedge clk); #1;
                    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0;
                    #1;
                    check("midrst_bin", LW'(o_binary), LW'(COLOR_WHITE));
                    check("midrst_de", LW'(o_de), LW'(0));
                    check("midrst_hv", LW'({o_hsync, o_vsync}), LW'(0));
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
                cyc(img[y][x], 1'b0, 1'b0, 1'b1, thr_a[y][x], en_a[y][x]);
            end
            for (int c = 0; c < HBL; c++)
                cyc(24'($urandom), c >= 2 && c < 6, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
        end
        for (int c = 0; c < 6; c++)
            cyc(24'($urandom), 1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
        check({name, "_sync"}, LW'(sync_err), LW'(0));
        check({name, "_blank"}, LW'(bad), LW'(0));
        check({name, "_rows"}, LW'(rows_seen), LW'(H));
        check({name, "_nblk"}, LW'(blk_cnt), LW'(exp_blk));
    endtask

    task automatic fill(input logic [23:0] p, input logic [7:0] t, input bit e);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                img[y][x] = p; thr_a[y][x] = t; en_a[y][x] = e;
            end
    endtask

    task automatic fill_random(input bit per_pixel);
        int t;
        int rx [4], ry [4], rw [4], rh [4];
        bit obj;
        t = int'($urandom_range(60, 200));
        for (int k = 0; k < 4; k++) begin
            rx[k] = int'($urandom_range(0, W - 1));
            ry[k] = int'($urandom_range(0, H - 1));
            rw[k] = int'($urandom_range(1, 14));
            rh[k] = int'($urandom_range(1, 9));
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                obj = 0;
                for (int k = 0; k < 4; k++)
                    if (x >= rx[k] && x < rx[k] + rw[k] && y >= ry[k] && y < ry[k] + rh[k]) obj = 1;
                if ($urandom_range(0, 49) == 0) obj = !obj;
                img[y][x] = obj ? {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))}
                                : {8'($urandom_range(215, 255)), 8'($urandom_range(215, 255)), 8'($urandom_range(215, 255))};
                if ($urandom_range(0, 9) == 0) img[y][x] = 24'($urandom);
                thr_a[y][x] = per_pixel ? 8'(t + int'($urandom_range(0, 3))) : 8'(t);
                en_a[y][x]  = per_pixel ? ($urandom_range(0, 7) != 0) : (((y / 8) % 2) == 0);
            end
    endtask

    task automatic single_px(input bit e);
        fill(COLOR_WHITE, 8'd128, e);
        img[40][50] = COLOR_BLACK;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bin", LW'(o_binary), LW'(COLOR_WHITE));
        check("rst_sync", LW'({o_hsync, o_vsync, o_de}), LW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        fill(COLOR_WHITE, 8'd128, 1'b1);
        run_frame("white", -1);
        check("white_cnt", LW'(blk_cnt), LW'(0));

        fill(COLOR_BLACK, 8'd128, 1'b1);
        run_frame("black", -1);
        check("black_cnt", LW'(blk_cnt), LW'((W - 2) * (H - 2)));
        check("black_box", LW'({16'(bx0), 16'(by0)}), LW'({16'd2, 16'd2}));

        single_px(1'b1);
        run_frame("px_on", -1);
        check("px_on_cnt", LW'(blk_cnt), LW'(0));

        single_px(1'b0);
        run_frame("px_off", -1);
        check("px_off_cnt", LW'(blk_cnt), LW'(1));
        check("px_off_pos", LW'({16'(last_x), 16'(last_y)}), LW'({16'd50, 16'd40}));

        fill(COLOR_WHITE, 8'd128, 1'b1);
        for (int y = 30; y <= 35; y++)
            for (int x = 60; x <= 69; x++) img[y][x] = COLOR_BLACK;
        run_frame("block", -1);
        check("block_cnt", LW'(blk_cnt), LW'(32));
        check("block_box", LW'({16'(bx0), 16'(bx1), 16'(by0), 16'(by1)}),
              LW'({16'd62, 16'd69, 16'd32, 16'd35}));

        fill(24'h808080, 8'd128, 1'b0);
        for (int y = 1; y < H; y += 2)
            for (int x = 0; x < W; x++) thr_a[y][x] = 8'd129;
        run_frame("gray", -1);
        check("gray_cnt", LW'(blk_cnt), LW'(W * (H / 2)));

        fill_random(1'b0);
        run_frame("rand0", -1);
        fill_random(1'b1);
        run_frame("rand1", -1);

        single_px(1'b1);
        run_frame("rstfrm", 20);

        single_px(1'b1);
        run_frame("post_on", -1);
        check("post_on_cnt", LW'(blk_cnt), LW'(0));
        single_px(1'b0);
        run_frame("post_off", -1);
        check("post_off_cnt", LW'(blk_cnt), LW'(1));
        check("post_off_pos", LW'({16'(last_x), 16'(last_y)}), LW'({16'd50, 16'd40}));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
